// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default width for the sequential divider
package div_pkg;
  localparam int DIV_N = 8;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/add_sub_n.sv
// add_sub_n: N-bit adder/subtractor; sel=1 gives a-b with c=1 meaning no borrow
// ports: a, b operands; sel 0=add 1=subtract; s result; c carry out (inverted borrow when subtracting)
module add_sub_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  output logic [N-1:0] s,
  output logic         c
);
  assign {c, s} = {1'b0, a} + {1'b0, sel ? ~b : b} + {{N{1'b0}}, sel};
endmodule

// File: rtl/div_seq_n.sv
// div_seq_n: restoring unsigned divider, one quotient bit per clock, start/done handshake
// ports: clk, rst (async, active high); start, dividend_in, divisor_in request;
//        quot_o, rem_o registered result; busy_o iterating; done_o one-cycle result pulse;
//        dz_o divide-by-zero flag with done_o (only when DIV_DZ_FAST_EN is defined, else 0)
import div_pkg::*;
module div_seq_n #(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend_in,
  input  logic [N-1:0] divisor_in,
  output logic [N-1:0] quot_o,
  output logic [N-1:0] rem_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         dz_o
);
  localparam int CW = $clog2(N);
  state_t state, state_n;
  logic [N-1:0] rem, quot, dvs, rem_nx, quot_nx;
  logic [N:0] sh, diff;
  logic [CW-1:0] cnt;
  logic co, qbit, go, dz_fast;
  // the partial remainder stays below the divisor between iterations, so its top bit is
  // always zero and only the low N bits need storing; it reappears in the shifted value
  assign sh = {rem, quot[N-1]};
  add_sub_n #(.N(N + 1)) u_sub (
    .a  (sh),
    .b  ({1'b0, dvs}),
    .sel(1'b1),
    .s  (diff),
    .c  (co)
  );
  assign qbit = co & ~diff[N];
  assign rem_nx = qbit ? diff[N-1:0] : sh[N-1:0];
  assign quot_nx = {quot[N-2:0], qbit};
  assign go = start & (state != CALC);
`ifdef DIV_DZ_FAST_EN
  logic dz;
  assign dz_fast = divisor_in == '0;
  assign dz_o = dz & (state == DONE);
`else
  assign dz_fast = 1'b0;
  assign dz_o = 1'b0;
`endif
  assign busy_o = state == CALC;
  assign done_o = state == DONE;
  always_comb begin
    state_n = state;
    if (state == CALC) state_n = cnt == '0 ? DONE : CALC;
    else if (go) state_n = dz_fast ? DONE : CALC;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      quot   <= '0;
      dvs    <= '0;
      cnt    <= '0;
      quot_o <= '0;
      rem_o  <= '0;
    end else begin
      state <= state_n;
      if (go) begin
        dvs  <= divisor_in;
        quot <= dividend_in;
        rem  <= '0;
        cnt  <= CW'(N - 1);
        if (dz_fast) begin
          quot_o <= '1;
          rem_o  <= dividend_in;
        end
      end else if (state == CALC) begin
        rem  <= rem_nx;
        quot <= quot_nx;
        cnt  <= cnt - 1'b1;
        if (cnt == '0) begin
          quot_o <= quot_nx;
          rem_o  <= rem_nx;
        end
      end
    end
  end
`ifdef DIV_DZ_FAST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dz <= 1'b0;
    else if (go) dz <= dz_fast;
  end
`endif
endmodule

// File: tb/tb_div_seq_n.sv
// tb_div_seq_n: directed and random scoreboard checks of div_seq_n at N=8 and N=16
module tb_div_seq_n;
  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, s16 = 1'b0;
  logic [7:0] dividend = '0, divisor = '0, quot, rem;
  logic [15:0] a16 = '0, b16 = '0, q16, r16;
  logic busy, done, dz, busy16, done16, dz16;
  int checks = 0, errors = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  div_seq_n #(.N(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend_in(dividend), .divisor_in(divisor),
    .quot_o(quot), .rem_o(rem), .busy_o(busy), .done_o(done), .dz_o(dz)
  );
  div_seq_n #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .start(s16), .dividend_in(a16), .divisor_in(b16),
    .quot_o(q16), .rem_o(r16), .busy_o(busy16), .done_o(done16), .dz_o(dz16)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.q = b == 0 ? 8'hff : a / b;
    e.r = b == 0 ? a : a % b;
`ifdef DIV_DZ_FAST_EN
    e.dz = b == 0;
    e.lat = b == 0 ? 1 : 9;
`else
    e.dz = 1'b0;
    e.lat = 9;
`endif
    sb.push_back(e);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int c0);
    exp_t e;
    int cyc = c0;
    int nb = 0;
    while (!done && cyc < 40) begin
      nb += int'(busy);
      @(negedge clk);
      cyc++;
    end
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".lat"}, cyc, e.lat);
    chk({tag, ".quot"}, quot, e.q);
    chk({tag, ".rem"}, rem, e.r);
    chk({tag, ".dz"}, dz, e.dz);
    chk({tag, ".busy_at_done"}, busy, 0);
    if (c0 == 1) chk({tag, ".busy_cycles"}, nb, e.lat - 1);
  endtask
  task automatic quiet(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      seen |= done | busy;
    end
    chk({tag, ".quiet"}, seen, 0);
  endtask
  initial begin
    logic [7:0] ra, rb;
    int c;
    repeat (2) @(negedge clk);
    chk("rst.quot", quot, 0);
    chk("rst.rem", rem, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.dz", dz, 0);
    rst = 1'b0;
    @(negedge clk);
    launch(100, 7);
    chk("d100_7.busy", busy, 1);
    wait_done("d100_7", 1);
    quiet("d100_7.pulse", 3);
    launch(255, 1);
    wait_done("b2b_a", 1);
    launch(5, 9);
    chk("b2b.hold_quot", quot, 255);
    wait_done("b2b_b", 1);
    quiet("b2b.pulse", 3);
    launch(200, 0);
    wait_done("dz200", 1);
    quiet("dz200.pulse", 3);
    launch(90, 4);
    repeat (3) @(negedge clk);
    start = 1'b1;
    dividend = 50;
    divisor = 3;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", 5);
    quiet("ign.single", 12);
    launch(90, 4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst.quot", quot, 0);
    chk("mid_rst.rem", rem, 0);
    chk("mid_rst.busy", busy, 0);
    chk("mid_rst.done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    quiet("mid_rst", 12);
    launch(9, 2);
    wait_done("post_rst", 1);
    repeat (20) begin
      ra = 8'($urandom);
      rb = 8'($urandom_range(1, 255));
      launch(ra, rb);
      wait_done("rand8", 1);
    end
    repeat (10) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom_range(1, 65535));
      s16 = 1'b1;
      @(negedge clk);
      s16 = 1'b0;
      c = 1;
      while (!done16 && c < 60) begin
        @(negedge clk);
        c++;
      end
      chk("rand16.lat", c, 17);
      chk("rand16.inv", 64'(q16) * 64'(b16) + 64'(r16), 64'(a16));
      chk("rand16.rem_lt", r16 < b16, 1);
      chk("rand16.dz", dz16, 0);
      chk("rand16.busy", busy16, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
